osd_spi_master: RTL

SPI master that sequences OSD commands from the core side onto the OSD's three-wire SPI port (`sck`, `ss`, `sdi`). It accepts one command at a time over a valid/ready handshake and serializes it MSB-first:
- OSD enable/disable.
- Write one 256-byte OSD line, fetched from a local byte store.
- Clear one line to zero.

It sits in the core's clock domain, between the core's menu/status logic and the OSD overlay block.

---
 rtl/osd_spi_master.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/osd_spi_master.sv
// Serialises OSD enable/disable, write-line and clear-line commands onto the
// OSD's three-wire SPI port, MSB first, fetching write payload from a byte store.
module osd_spi_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [2:0] cmd_line,
  output logic       rd_req,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       sck,
  output logic       ss,
  output logic       sdi
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_HOLD,
    S_GAP
  } state_t;

  localparam logic [1:0] OP_WRITE = 2'b10;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  div_cnt;
  logic        div_last;
  logic [2:0]  bit_cnt;
  logic [8:0]  byte_cnt;
  logic [8:0]  last_byte;
  logic        last_bit;
  logic [1:0]  op_q;
  logic [7:0]  shreg;
  logic [7:0]  hold;
  logic        cap_pend;
  logic [7:0]  cmd_byte;
  logic [7:0]  next_byte;
  logic        accept;
  logic        enter_high;

  assign div_last  = (div_cnt == 8'(CLK_DIV - 1));
  assign last_byte = op_q[1] ? 9'd256 : 9'd0;
  assign last_bit  = (bit_cnt == 3'd7) && (byte_cnt == last_byte);
  assign cmd_byte  = cmd_op[1] ? {5'b00100, cmd_line} : {7'b0100000, cmd_op[0]};
  assign sdi       = shreg[7];

  // With CLK_DIV=2 the capture and the load fall on the same edge, so the
  // load takes rd_data directly while the capture is still pending.
  assign next_byte = (op_q != OP_WRITE) ? 8'h00 :
                     cap_pend           ? rd_data : hold;

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    busy       = (state != S_IDLE);
    cmd_ready  = (state == S_IDLE);
    sck        = (state == S_HIGH);
    ss         = 1'b1;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          accept    = 1'b1;
          state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        ss = 1'b0;
        if (div_last) state_nxt = S_HIGH;
      end
      S_HIGH: begin
        ss = 1'b0;
        if (div_last) state_nxt = last_bit ? S_HOLD : S_LOW;
      end
      S_LOW: begin
        ss = 1'b0;
        if (div_last) state_nxt = S_HIGH;
      end
      S_HOLD: begin
        ss = 1'b0;
        if (div_last) state_nxt = S_GAP;
      end
      S_GAP: begin
        if (div_last) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign enter_high = (state_nxt == S_HIGH) && (state != S_HIGH);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      op_q     <= '0;
      shreg    <= '0;
      hold     <= '0;
      cap_pend <= 1'b0;
      rd_req   <= 1'b0;
      rd_addr  <= '0;
    end else begin
      state    <= state_nxt;
      rd_req   <= 1'b0;
      cap_pend <= rd_req;

      if (state == S_IDLE || div_last) div_cnt <= '0;
      else                             div_cnt <= div_cnt + 8'd1;

      if (cap_pend) hold <= rd_data;

      if (accept) begin
        op_q     <= cmd_op;
        bit_cnt  <= '0;
        byte_cnt <= '0;
        shreg    <= cmd_byte;
      end

      // Fetch payload byte k while bit 0 of byte k-1 is on the wire.
      if (enter_high && bit_cnt == 3'd7 && op_q == OP_WRITE && byte_cnt != 9'd256) begin
        rd_req  <= 1'b1;
        rd_addr <= byte_cnt[7:0];
      end

      if (state == S_HIGH && state_nxt == S_LOW) begin
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_cnt <= byte_cnt + 9'd1;
          shreg    <= next_byte;
        end else begin
          shreg <= {shreg[6:0], 1'b0};
        end
      end
    end
  end

endmodule
